// File: rtl/regfile_dump.sv
// regfile_dump: debug read-out engine for the core's register file.
//
// On a start pulse the engine walks the register-file read address from
// FIRST_REG to LAST_REG. For each register it snapshots the 32-bit read
// data, then streams a 5-byte frame over a valid/ready byte interface:
//   byte 0    : header {3'b101, idx}
//   bytes 1..4: snapshot, MSB first
//
// Handshake: a byte moves when tx_valid && tx_ready are both high at a
// rising clk edge. Once tx_valid is raised, tx_valid and tx_data hold
// steady until that transfer happens, and tx_data is 0 whenever
// tx_valid is 0.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     dump request, sampled only while idle
//   ra        register-file read address (always equal to idx)
//   rd        register-file read data, combinational from ra
//   tx_data   stream byte
//   tx_valid  stream byte offered
//   tx_ready  stream consumer accepts
//   busy      high whenever the engine is not idle
//   done      one-cycle pulse after the last byte of a dump is accepted
module regfile_dump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  ra,
  input  logic [31:0] rd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [4:0]  idx, idx_nx;
  logic [2:0]  bcnt, bcnt_nx;
  logic [31:0] shadow, shadow_nx;

  assign ra = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= FIRST_IDX;
      bcnt   <= 3'd0;
      shadow <= 32'd0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      bcnt   <= bcnt_nx;
      shadow <= shadow_nx;
    end
  end

  // All stream outputs decode directly from the state registers, so an
  // asynchronous reset pulls tx_valid/tx_data low immediately and the
  // values are naturally stable while a byte is stalled.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    bcnt_nx   = bcnt;
    shadow_nx = shadow;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    done      = 1'b0;
    busy      = (state != IDLE);

    case (state)
      IDLE: begin
        if (start) begin
          idx_nx   = FIRST_IDX;
          state_nx = LOAD;
        end
      end

      LOAD: begin
        // Snapshot taken here; later register-file writes cannot
        // disturb the frame being sent.
        shadow_nx = rd;
        bcnt_nx   = 3'd0;
        state_nx  = SEND;
      end

      SEND: begin
        tx_valid = 1'b1;
        case (bcnt)
          3'd0:    tx_data = {3'b101, idx};
          3'd1:    tx_data = shadow[31:24];
          3'd2:    tx_data = shadow[23:16];
          3'd3:    tx_data = shadow[15:8];
          default: tx_data = shadow[7:0];
        endcase
        if (tx_ready) begin
          if (bcnt != 3'd4) begin
            bcnt_nx = bcnt + 3'd1;
          end else if (idx != LAST_IDX) begin
            idx_nx   = idx + 5'd1;
            state_nx = LOAD;
          end else begin
            state_nx = DONE;
          end
        end
      end

      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump.sv
module tb_regfile_dump;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst, start, tx_ready;
  logic [4:0]  ra;
  logic [31:0] rd;
  logic [7:0]  tx_data;
  logic        tx_valid, busy, done;

  logic        rst_b, start_b, tx_ready_b;
  logic [4:0]  ra_b;
  logic [31:0] rd_b;
  logic [7:0]  tx_data_b;
  logic        tx_valid_b, busy_b, done_b;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // register-file model with a combinational read port
  logic [31:0] regs [32];
  assign rd   = regs[ra];
  assign rd_b = regs[ra_b];

  regfile_dump u_dut (
    .clk(clk), .rst(rst), .start(start), .ra(ra), .rd(rd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  regfile_dump #(.FIRST_REG(3), .LAST_REG(4)) u_rng (
    .clk(clk), .rst(rst_b), .start(start_b), .ra(ra_b), .rd(rd_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .busy(busy_b), .done(done_b)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp_b_q[$];
  int n_vec = 0;
  int n_err = 0;
  int xfers_a = 0, xfers_b = 0;
  int done_cyc_a = 0, done_cyc_b = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_byte = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_dump(input int first, input int last, input bit which);
    logic [7:0]  b;
    logic [31:0] v;
    logic [4:0]  r5;
    for (int r = first; r <= last; r++) begin
      r5 = r[4:0];
      v  = (r == 0) ? 32'd0 : regs[r];
      for (int k = 0; k < 5; k++) begin
        case (k)
          0: b = {3'b101, r5};
          1: b = v[31:24];
          2: b = v[23:16];
          3: b = v[15:8];
          default: b = v[7:0];
        endcase
        if (which) exp_b_q.push_back(b);
        else exp_q.push_back(b);
      end
    end
  endtask

  // Outputs sampled at negedge; a transfer seen here completes at the
  // following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(hold_byte));
      end
      hold_pend = tx_valid && !tx_ready;
      hold_byte = tx_data;
      if (tx_valid && tx_ready) begin
        xfers_a++;
        if (exp_q.size() == 0) chk("xfer_extra", 32'(tx_data), 32'h100);
        else chk("xfer", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      if (done) done_cyc_a = cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_b) begin
      if (tx_valid_b && tx_ready_b) begin
        xfers_b++;
        if (exp_b_q.size() == 0) chk("xfer_b_extra", 32'(tx_data_b), 32'h100);
        else chk("xfer_b", 32'(tx_data_b), 32'(exp_b_q.pop_front()));
      end
      if (done_b) done_cyc_b = cyc + 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(output int e);
    done_cyc_a = 0;
    start = 1'b1;
    step();
    e = cyc;
    start = 1'b0;
  endtask

  task automatic start_bb(output int e);
    done_cyc_b = 0;
    start_b = 1'b1;
    step();
    e = cyc;
    start_b = 1'b0;
  endtask

  task automatic wait_xfers_a(input int target);
    for (int i = 0; i < 400 && !(xfers_a == target && tx_valid); i++) step();
  endtask

  task automatic wait_done_a(input int e, input int n_regs, input int stall, input int xf0);
    for (int i = 0; i < 400 && done_cyc_a == 0; i++) step();
    chk("done_cycle", 32'(done_cyc_a), 32'(e + 6 * n_regs + 1 + stall));
    chk("xfer_count", 32'(xfers_a - xf0), 32'(5 * n_regs));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e, xf0;
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
    rst = 1'b1; start = 1'b0; tx_ready = 1'b1;
    rst_b = 1'b1; start_b = 1'b0; tx_ready_b = 1'b1;

    // reset: hold 3 cycles, release mid-cycle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; rst_b = 1'b0;
    #1;
    chk("rst_ra", 32'(ra), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ra_b", 32'(ra_b), 32'd3);
    step();

    // dump 1: full range, no backpressure
    push_dump(0, 31, 1'b0);
    xf0 = xfers_a;
    start_a(e);
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_valid", 32'(tx_valid), 32'd0);
    step();
    chk("send_valid", 32'(tx_valid), 32'd1);
    chk("first_hdr", 32'(tx_data), 32'hA0);
    wait_done_a(e, 32, 0, xf0);
    repeat (3) step();

    // dump 2: stall 10 cycles on byte 2 of x5
    push_dump(0, 31, 1'b0);
    xf0 = xfers_a;
    start_a(e);
    wait_xfers_a(xf0 + 27);
    chk("stall_byte", 32'(tx_data), 32'h00);
    tx_ready = 1'b0;
    repeat (10) step();
    tx_ready = 1'b1;
    wait_done_a(e, 32, 10, xf0);
    repeat (3) step();

    // dump 3: x7 rewritten during its header; start pulses in SEND and DONE
    push_dump(0, 31, 1'b0);
    xf0 = xfers_a;
    start_a(e);
    wait_xfers_a(xf0 + 35);
    chk("x7_hdr", 32'(tx_data), 32'hA7);
    regs[7] = 32'hDEAD_BEEF;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 400 && !done; i++) step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("done_cycle3", 32'(done_cyc_a), 32'(e + 193));
    chk("xfer_count3", 32'(xfers_a - xf0), 32'd160);
    repeat (20) step();
    chk("ignored_busy", 32'(busy), 32'd0);
    chk("ignored_xfers", 32'(xfers_a - xf0), 32'd160);

    // dump 4 shows the new x7; dump 5 starts in the first idle cycle
    push_dump(0, 31, 1'b0);
    xf0 = xfers_a;
    start_a(e);
    wait_done_a(e, 32, 0, xf0);
    push_dump(0, 31, 1'b0);
    xf0 = xfers_a;
    start_a(e);
    chk("restart_busy", 32'(busy), 32'd1);
    wait_done_a(e, 32, 0, xf0);
    repeat (3) step();

    // asynchronous reset in the middle of a frame
    push_dump(0, 31, 1'b0);
    xf0 = xfers_a;
    start_a(e);
    wait_xfers_a(xf0 + 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(tx_valid), 32'd0);
    chk("arst_data", 32'(tx_data), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ra", 32'(ra), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step();

    // narrow instance: reset after 7 bytes, then a clean dump of x3..x4
    push_dump(3, 4, 1'b1);
    xf0 = xfers_b;
    start_bb(e);
    for (int i = 0; i < 100 && !(xfers_b == xf0 + 7 && tx_valid_b); i++) step();
    #2;
    rst_b = 1'b1;
    #1;
    chk("b_arst_valid", 32'(tx_valid_b), 32'd0);
    chk("b_arst_ra", 32'(ra_b), 32'd3);
    exp_b_q.delete();
    @(negedge clk);
    rst_b = 1'b0;
    step();
    push_dump(3, 4, 1'b1);
    xf0 = xfers_b;
    start_bb(e);
    chk("b_first_hdr_pending", 32'(exp_b_q[0]), 32'hA3);
    for (int i = 0; i < 100 && done_cyc_b == 0; i++) step();
    chk("b_done_cycle", 32'(done_cyc_b), 32'(e + 13));
    chk("b_xfer_count", 32'(xfers_b - xf0), 32'd10);
    chk("b_queue_empty", 32'(exp_b_q.size()), 32'd0);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
